// File: rtl/mfp_input_debounce_if.sv
// Board-input bundle between the Nexys4 DDR pins and the debounce stage.
// The master side drives raw pins; the slave side (the debouncer) returns conditioned levels.
interface mfp_input_debounce_if #(
  parameter int N_PB = 5,
  parameter int N_SW = 16
);
  logic [N_PB-1:0] PB_Raw;
  logic [N_SW-1:0] SW_Raw;
  logic [N_PB-1:0] PB_Db;
  logic [N_SW-1:0] SW_Db;
  logic [N_PB-1:0] PB_Press;

  modport master (
    output PB_Raw,
    output SW_Raw,
    input  PB_Db,
    input  SW_Db,
    input  PB_Press
  );

  modport slave (
    input  PB_Raw,
    input  SW_Raw,
    output PB_Db,
    output SW_Db,
    output PB_Press
  );
endinterface

// File: rtl/mfp_input_debounce.sv
// Synchronises and debounces pushbuttons and switches with a shared sample tick.
// Define MFP_DEBOUNCE_PRESS_EN to build the one-cycle PB_Press pulse logic; otherwise PB_Press is 0.
module mfp_input_debounce #(
  parameter int N_PB         = 5,
  parameter int N_SW         = 16,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic                 SI_ClkIn,
  input  logic                 SI_Reset_N,
  mfp_input_debounce_if.slave  io
);

  localparam int N  = N_PB + N_SW;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam int DW = $clog2(TICK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [N-1:0]  raw;
  logic [N-1:0]  sync_q1;
  logic [N-1:0]  sync_q2;
  logic [N-1:0]  db_q;
  logic [N-1:0]  accept;
  logic [DW-1:0] div_cnt;
  logic          tick;

  // Pushbuttons occupy the low bits, switches the high bits.
  assign raw = {io.SW_Raw, io.PB_Raw};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  for (genvar g = 0; g < N; g++) begin : g_slice
    logic [CW-1:0] cnt_q;
    logic          out_q;

    // Final tick of a full mismatching run: the new level is taken this edge.
    assign accept[g] = tick && (sync_q2[g] != out_q) && (cnt_q == CNT_LAST);
    assign db_q[g]   = out_q;

    // Any cycle where the input agrees with the output clears progress, tick or not.
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
      if (!SI_Reset_N) begin
        cnt_q <= '0;
        out_q <= 1'b0;
      end else if (sync_q2[g] == out_q) begin
        cnt_q <= '0;
      end else if (accept[g]) begin
        out_q <= sync_q2[g];
        cnt_q <= '0;
      end else if (tick) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign io.PB_Db = db_q[N_PB-1:0];
  assign io.SW_Db = db_q[N-1:N_PB];

`ifdef MFP_DEBOUNCE_PRESS_EN
  logic [N_PB-1:0] press_q;

  // Registered alongside the debounced rise so the pulse lands on the same edge as PB_Db.
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      press_q <= '0;
    end else begin
      press_q <= accept[N_PB-1:0] & sync_q2[N_PB-1:0];
    end
  end

  assign io.PB_Press = press_q;
`else
  assign io.PB_Press = '0;
`endif

endmodule
